// File: rtl/lights_sequencer_pkg.sv
// lights_pkg: shared colour indices, mode encodings and the colour step
// function for the lighting blocks.
package lights_pkg;

   localparam logic [2:0] COL_BLACK   = 3'd0;
   localparam logic [2:0] COL_BLUE    = 3'd1;
   localparam logic [2:0] COL_GREEN   = 3'd2;
   localparam logic [2:0] COL_CYAN    = 3'd3;
   localparam logic [2:0] COL_RED     = 3'd4;
   localparam logic [2:0] COL_MAGENTA = 3'd5;
   localparam logic [2:0] COL_YELLOW  = 3'd6;
   localparam logic [2:0] COL_WHITE   = 3'd7;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_AUTO   = 1'b1;

   // Colour sequence step: black/white are never reached by stepping and
   // always recover to blue; yellow wraps back to blue.
   function automatic logic [2:0] next_colour(input logic [2:0] cur,
                                              input logic       adv);
      logic [2:0] nxt;
      nxt = cur;
      if (cur == COL_BLACK || cur == COL_WHITE)
         nxt = COL_BLUE;
      else if (adv)
         nxt = (cur == COL_YELLOW) ? COL_BLUE : cur + 3'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/lights_sequencer_if.sv
// lights_sequencer_if: control inputs and LED outputs of the lights sequencer.
// LIGHTS_DIM_EN adds the 2-bit dim input.
interface lights_sequencer_if #(
   parameter int CH_W     = 8,
   parameter int PERIOD_W = 8
);
   logic                  sel;
   logic                  button;
   logic                  mode;
   logic [PERIOD_W-1:0]   period;
   logic [3*CH_W-1:0]     light;
   logic [2:0]            colour;
`ifdef LIGHTS_DIM_EN
   logic [1:0]            dim;

   modport master (output sel, button, mode, period, dim,
                   input  light, colour);
   modport slave  (input  sel, button, mode, period, dim,
                   output light, colour);
`else
   modport master (output sel, button, mode, period,
                   input  light, colour);
   modport slave  (input  sel, button, mode, period,
                   output light, colour);
`endif
endinterface

// File: rtl/lights_sequencer_colour_rom.sv
// colour_rom: combinational colour index to {R,G,B} full-scale lookup.
// bit2 drives R, bit1 drives G, bit0 drives B.
module colour_rom
   import lights_pkg::*;
#(
   parameter int CH_W = 8
) (
   input  logic [2:0]          colour,
   output logic [3*CH_W-1:0]   rgb
);

   localparam logic [CH_W-1:0] FULL = '1;
   localparam logic [CH_W-1:0] ZERO = '0;

   // Table lookup of the eight colour indices
   always_comb begin
      rgb = {ZERO, ZERO, ZERO};
      case (colour)
         COL_BLACK:   rgb = {ZERO, ZERO, ZERO};
         COL_BLUE:    rgb = {ZERO, ZERO, FULL};
         COL_GREEN:   rgb = {ZERO, FULL, ZERO};
         COL_CYAN:    rgb = {ZERO, FULL, FULL};
         COL_RED:     rgb = {FULL, ZERO, ZERO};
         COL_MAGENTA: rgb = {FULL, ZERO, FULL};
         COL_YELLOW:  rgb = {FULL, FULL, ZERO};
         COL_WHITE:   rgb = {FULL, FULL, FULL};
         default:     rgb = {ZERO, ZERO, ZERO};
      endcase
   end

endmodule

// File: rtl/lights_sequencer.sv
// lights_sequencer: colour sequence FSM (manual step or auto-cycle with a
// programmable dwell), colour lookup, registered RGB and white/colour select.
// Optional feature macro: LIGHTS_DIM_EN (per-component right-shift by dim).
module lights_sequencer
   import lights_pkg::*;
#(
   parameter int CH_W     = 8,
   parameter int PERIOD_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   lights_sequencer_if.slave      bus
);

   logic [2:0]           colour_q;
   logic [PERIOD_W-1:0]  tick_q;
   logic                 mode_q;
   logic                 mode_chg;
   logic                 tick_hit;
   logic                 auto_adv;
   logic                 man_adv;
   logic                 advance;
   logic [3*CH_W-1:0]    rom_rgb;
   logic [3*CH_W-1:0]    scaled_rgb;
   logic [3*CH_W-1:0]    rgb_p1;

   // A mode change suppresses the auto advance on that edge; a manual
   // press still counts when the new mode is manual.
   assign mode_chg = (bus.mode != mode_q);
   assign tick_hit = (tick_q >= bus.period);
   assign auto_adv = (bus.mode == MODE_AUTO) && !bus.button && !mode_chg && tick_hit;
   assign man_adv  = (bus.mode == MODE_MANUAL) && bus.button;
   assign advance  = auto_adv || man_adv;

   // Registered copy of mode for change detection
   always_ff @(posedge clk) begin
      if (rst) mode_q <= MODE_MANUAL;
      else     mode_q <= bus.mode;
   end

   // Dwell counter: clears on mode change or on reaching period, freezes
   // while paused, idles at zero in manual mode
   always_ff @(posedge clk) begin
      if (rst)
         tick_q <= '0;
      else if (mode_chg)
         tick_q <= '0;
      else if (bus.mode == MODE_AUTO) begin
         if (!bus.button)
            tick_q <= tick_hit ? '0 : tick_q + 1'b1;
      end else
         tick_q <= '0;
   end

   // Colour sequence state
   always_ff @(posedge clk) begin
      if (rst) colour_q <= COL_BLACK;
      else     colour_q <= next_colour(colour_q, advance);
   end

   colour_rom #(.CH_W(CH_W)) u_rom (
      .colour (colour_q),
      .rgb    (rom_rgb)
   );

`ifdef LIGHTS_DIM_EN
   function automatic logic [CH_W-1:0] dim_scale(input logic [CH_W-1:0] c,
                                                 input logic [1:0]      d);
      return c >> d;
   endfunction

   // Per-component dimming, sampled with the same edge as colour
   always_comb begin
      scaled_rgb = '0;
      for (int i = 0; i < 3; i++)
         scaled_rgb[i*CH_W +: CH_W] = dim_scale(rom_rgb[i*CH_W +: CH_W], bus.dim);
   end
`else
   assign scaled_rgb = rom_rgb;
`endif

   // Stage p1: registered RGB, one cycle behind colour
   always_ff @(posedge clk) begin
      if (rst) rgb_p1 <= '0;
      else     rgb_p1 <= scaled_rgb;
   end

   assign bus.light  = bus.sel ? rgb_p1 : {(3*CH_W){1'b1}};
   assign bus.colour = colour_q;

endmodule

// File: tb/tb_lights_sequencer.sv
// tb_lights_sequencer: directed testbench for lights_sequencer (CH_W=8,
// PERIOD_W=8). Compile with LIGHTS_DIM_EN to include the dim scenario.
module tb_lights_sequencer;

   logic clk = 1'b0;
   logic rst;
   int   n_pass  = 0;
   int   n_total = 0;

   lights_sequencer_if #(.CH_W(8), .PERIOD_W(8)) bus ();

   lights_sequencer #(.CH_W(8), .PERIOD_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.sel = 1'b0; bus.button = 1'b0; bus.mode = 1'b0; bus.period = 8'd0;
`ifdef LIGHTS_DIM_EN
      bus.dim = 2'd0;
`endif
      step(); step();
      n_total++;
      if (bus.light !== 24'hFFFFFF) $display("FAIL reset_white: got %h want %h", bus.light, 24'hFFFFFF);
      else n_pass++;
      bus.sel = 1'b1; #1;
      n_total++;
      if (bus.light !== 24'h000000) $display("FAIL reset_light: got %h want %h", bus.light, 24'h000000);
      else n_pass++;
      n_total++;
      if (bus.colour !== 3'd0) $display("FAIL reset_colour: got %0d want 0", bus.colour);
      else n_pass++;
   endtask

   task automatic test_recovery();
      rst = 1'b0;
      step();
      n_total++;
      if (bus.colour !== 3'd1 || bus.light !== 24'h000000)
         $display("FAIL recover_first: got col %0d light %h want col 1 light 000000", bus.colour, bus.light);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if (bus.colour !== 3'd1 || bus.light !== 24'h0000FF)
            $display("FAIL recover_hold%0d: got col %0d light %h want col 1 light 0000ff", i, bus.colour, bus.light);
         else n_pass++;
      end
   endtask

   task automatic test_manual();
      logic [2:0]  col_exp [7] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd1, 3'd2};
      logic [23:0] lgt_exp [7] = '{24'h0000FF, 24'h00FF00, 24'h00FFFF, 24'hFF0000,
                                   24'hFF00FF, 24'hFFFF00, 24'h0000FF};
      bus.button = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         n_total++;
         if (bus.colour !== col_exp[i] || bus.light !== lgt_exp[i])
            $display("FAIL manual_step%0d: got col %0d light %h want col %0d light %h",
                     i, bus.colour, bus.light, col_exp[i], lgt_exp[i]);
         else n_pass++;
      end
      bus.button = 1'b0;
   endtask

   task automatic test_auto();
      logic [2:0] col_exp [8] = '{3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
      bus.mode = 1'b1; bus.period = 8'd3;
      step();   // mode-change edge: counter cleared, colour holds
      n_total++;
      if (bus.colour !== 3'd2) $display("FAIL auto_modechg: got %0d want 2", bus.colour);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         step();
         n_total++;
         if (bus.colour !== col_exp[i])
            $display("FAIL auto_cycle%0d: got %0d want %0d", i, bus.colour, col_exp[i]);
         else n_pass++;
      end
      step(); step();   // counter now 2
      bus.button = 1'b1;
      for (int i = 0; i < 10; i++) step();
      n_total++;
      if (bus.colour !== 3'd4) $display("FAIL auto_pause: got %0d want 4", bus.colour);
      else n_pass++;
      bus.button = 1'b0;
      step();
      n_total++;
      if (bus.colour !== 3'd4) $display("FAIL auto_resume1: got %0d want 4", bus.colour);
      else n_pass++;
      step();
      n_total++;
      if (bus.colour !== 3'd5) $display("FAIL auto_resume2: got %0d want 5", bus.colour);
      else n_pass++;
   endtask

   task automatic test_mode_switch();
      bus.period = 8'd5;
      step(); step();   // counter at 2
      bus.mode = 1'b0;
      step();
      bus.mode = 1'b1;
      step();
      n_total++;
      if (bus.colour !== 3'd5) $display("FAIL modesw_hold: got %0d want 5", bus.colour);
      else n_pass++;
      for (int i = 0; i < 5; i++) step();
      n_total++;
      if (bus.colour !== 3'd5) $display("FAIL modesw_cleared: got %0d want 5", bus.colour);
      else n_pass++;
      step();
      n_total++;
      if (bus.colour !== 3'd6) $display("FAIL modesw_fire: got %0d want 6", bus.colour);
      else n_pass++;
      for (int i = 0; i < 5; i++) step();   // counter at period
      bus.mode = 1'b0;
      step();
      n_total++;
      if (bus.colour !== 3'd6) $display("FAIL modesw_wins: got %0d want 6", bus.colour);
      else n_pass++;
   endtask

   task automatic test_period_zero();
      logic [2:0] col_exp [3] = '{3'd6, 3'd1, 3'd2};
      bus.mode = 1'b1; bus.period = 8'd0;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if (bus.colour !== col_exp[i])
            $display("FAIL period0_%0d: got %0d want %0d", i, bus.colour, col_exp[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid();
      step(); step(); step();
      n_total++;
      if (bus.colour !== 3'd5) $display("FAIL midrun_pre: got %0d want 5", bus.colour);
      else n_pass++;
      rst = 1'b1; bus.button = 1'b1;
      step();
      n_total++;
      if (bus.colour !== 3'd0 || bus.light !== 24'h000000)
         $display("FAIL midrun_reset: got col %0d light %h want col 0 light 000000", bus.colour, bus.light);
      else n_pass++;
      bus.sel = 1'b0; #1;
      n_total++;
      if (bus.light !== 24'hFFFFFF) $display("FAIL midrun_white: got %h want ffffff", bus.light);
      else n_pass++;
      bus.sel = 1'b1;
   endtask

`ifdef LIGHTS_DIM_EN
   task automatic test_dim();
      bus.mode = 1'b0; bus.button = 1'b0;
      step();   // clear registered mode
      rst = 1'b0;
      step();   // colour 1
      bus.button = 1'b1;
      step(); step(); step();   // colour 4 (red)
      bus.button = 1'b0; bus.dim = 2'd2;
      step();
      n_total++;
      if (bus.light !== 24'h3F0000) $display("FAIL dim_red: got %h want 3f0000", bus.light);
      else n_pass++;
      bus.sel = 1'b0; #1;
      n_total++;
      if (bus.light !== 24'hFFFFFF) $display("FAIL dim_white: got %h want ffffff", bus.light);
      else n_pass++;
      bus.sel = 1'b1;
   endtask
`endif

   initial begin
      test_reset();
      test_recovery();
      test_manual();
      test_auto();
      test_mode_switch();
      test_period_zero();
      test_reset_mid();
`ifdef LIGHTS_DIM_EN
      test_dim();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
